csr_target: RTL and testbench

Slave-side adapter between the shared CSR bus and a block's local register file. It decodes requests whose `select` matches this target's `csr_select`. For each matching request it issues exactly one single-cycle local access, acknowledges the bus, and returns read data. Every peripheral with CSRs instantiates one next to its register logic; the peripheral supplies read data combinationally.

---
 rtl/csr_pkg.sv | 32 +++
 rtl/csr_target.sv | 80 ++++++++
 tb/tb_csr_target.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR bus widths, bus/access structs and the target FSM state type.
package csr_pkg;

    localparam int SELECT_W = 16;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic                valid;
        logic                read_not_write;
        logic [SELECT_W-1:0] select;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W-1:0]   data;
    } t_csr_request;

    typedef struct packed {
        logic              acknowledge;
        logic              read_data_valid;
        logic              read_data_error;
        logic [DATA_W-1:0] read_data;
    } t_csr_response;

    typedef struct packed {
        logic              valid;
        logic              read_not_write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } t_csr_access;

    typedef enum logic [1:0] {IDLE, ACCESS, READ_RESP, HOLD} t_csr_state;

endpackage

// File: rtl/csr_target.sv
// csr_target: turns one matching CSR bus request into a single-cycle local access and a bus response.
module csr_target
    import csr_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [SELECT_W-1:0] csr_select,
    input  logic                csr_request__valid,
    input  logic                csr_request__read_not_write,
    input  logic [SELECT_W-1:0] csr_request__select,
    input  logic [ADDR_W-1:0]   csr_request__address,
    input  logic [DATA_W-1:0]   csr_request__data,
    input  logic [DATA_W-1:0]   csr_access_data,
    output logic                csr_access__valid,
    output logic                csr_access__read_not_write,
    output logic [ADDR_W-1:0]   csr_access__address,
    output logic [DATA_W-1:0]   csr_access__data,
    output logic                csr_response__acknowledge,
    output logic                csr_response__read_data_valid,
    output logic                csr_response__read_data_error,
    output logic [DATA_W-1:0]   csr_response__read_data
);

    t_csr_state        state, state_next;
    logic              rnw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              hit;
    t_csr_access       access;
    t_csr_response     response;

    assign hit = csr_request__valid && (csr_request__select == csr_select);

    // HOLD only exits on a low valid sample, so a held request is never re-accepted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = hit ? ACCESS : IDLE;
            ACCESS:    state_next = rnw_q ? READ_RESP : HOLD;
            READ_RESP: state_next = HOLD;
            HOLD:      state_next = csr_request__valid ? HOLD : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && hit) begin
                rnw_q   <= csr_request__read_not_write;
                addr_q  <= csr_request__address;
                wdata_q <= csr_request__data;
            end
            if (state == ACCESS && rnw_q)
                rdata_q <= csr_access_data;
        end
    end

    always_comb begin
        access   = '{valid: state == ACCESS, read_not_write: rnw_q, address: addr_q, data: wdata_q};
        response = '{acknowledge: state != IDLE, read_data_valid: state == READ_RESP,
                     read_data_error: 1'b0, read_data: (state == READ_RESP) ? rdata_q : '0};
    end

    assign csr_access__valid             = access.valid;
    assign csr_access__read_not_write    = access.read_not_write;
    assign csr_access__address           = access.address;
    assign csr_access__data              = access.data;
    assign csr_response__acknowledge     = response.acknowledge;
    assign csr_response__read_data_valid = response.read_data_valid;
    assign csr_response__read_data_error = response.read_data_error;
    assign csr_response__read_data       = response.read_data;

endmodule

// File: tb/tb_csr_target.sv
// tb_csr_target: directed and randomized CSR transactions checked cycle by cycle against a transaction-level timing model.
module tb_csr_target;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] csr_select;
    logic        req_valid, req_rnw;
    logic [15:0] req_select, req_address;
    logic [31:0] req_data, csr_access_data;
    logic        access_valid, access_rnw;
    logic [15:0] access_address;
    logic [31:0] access_data;
    logic        ack, rdv, rde;
    logic [31:0] read_data;

    int vectors = 0;
    int miscompares = 0;

    // Model of the last accepted request; the access fields must show it at all times.
    logic        exp_rnw = 1'b0;
    logic [15:0] exp_addr = '0;
    logic [31:0] exp_data = '0;

    csr_target dut (
        .clk                           (clk),
        .reset                         (reset),
        .csr_select                    (csr_select),
        .csr_request__valid            (req_valid),
        .csr_request__read_not_write   (req_rnw),
        .csr_request__select           (req_select),
        .csr_request__address          (req_address),
        .csr_request__data             (req_data),
        .csr_access_data               (csr_access_data),
        .csr_access__valid             (access_valid),
        .csr_access__read_not_write    (access_rnw),
        .csr_access__address           (access_address),
        .csr_access__data              (access_data),
        .csr_response__acknowledge     (ack),
        .csr_response__read_data_valid (rdv),
        .csr_response__read_data_error (rde),
        .csr_response__read_data       (read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag, bit av, bit a, bit rv, logic [31:0] rd);
        chk({tag, ".access_valid"}, 32'(access_valid), 32'(av));
        chk({tag, ".acknowledge"}, 32'(ack), 32'(a));
        chk({tag, ".read_data_valid"}, 32'(rdv), 32'(rv));
        chk({tag, ".read_data"}, read_data, rd);
        chk({tag, ".read_data_error"}, 32'(rde), 32'd0);
        chk({tag, ".access_rnw"}, 32'(access_rnw), 32'(exp_rnw));
        chk({tag, ".access_address"}, 32'(access_address), 32'(exp_addr));
        chk({tag, ".access_data"}, access_data, exp_data);
    endtask

    // Entered just after a rising edge with the target idle. Valid is high in cycles 0..hold.
    // A hit is acknowledged from cycle 1 through the later of the first HOLD cycle and the first low-valid cycle.
    task automatic run_txn(string tag, bit match, bit rnw, logic [15:0] a, logic [31:0] d, int hold);
        int first_hold, last, n;
        logic [31:0] rval;
        first_hold = rnw ? 3 : 2;
        last = (first_hold > hold + 1) ? first_hold : hold + 1;
        n = match ? last + 1 : hold + 1;
        rval = '0;
        req_rnw = rnw;
        req_select = match ? csr_select : csr_select ^ (16'h1 << $urandom_range(15));
        req_address = a;
        req_data = d;
        for (int c = 0; c <= n; c++) begin
            req_valid = (c <= hold);
            csr_access_data = $urandom;
            if (c == 1) rval = csr_access_data;
            if (match && c == 1) begin
                exp_rnw = rnw;
                exp_addr = a;
                exp_data = d;
            end
            @(negedge clk);
            chk_all(tag, match && c == 1, match && c >= 1 && c <= last, match && rnw && c == 2,
                    (match && rnw && c == 2) ? rval : 32'd0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        csr_select = 16'h0005;
        csr_access_data = '0;
        reset = 1'b1;
        req_valid = 1'b1;
        req_rnw = 1'b0;
        req_select = 16'h0005;
        req_address = 16'h0010;
        req_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all("reset", 1'b0, 1'b0, 1'b0, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;

        run_txn("write", 1'b1, 1'b0, 16'h0010, 32'hDEADBEEF, 1);
        run_txn("read", 1'b1, 1'b1, 16'h0003, 32'h0, 1);
        run_txn("nomatch", 1'b0, 1'b0, 16'h0020, 32'hCAFEF00D, 9);
        run_txn("held", 1'b1, 1'b0, 16'h0030, 32'h11112222, 6);
        run_txn("fresh", 1'b1, 1'b1, 16'h0031, 32'h0, 0);

        // Reset lands in the ACCESS cycle of a read: the response must never appear.
        req_valid = 1'b1;
        req_rnw = 1'b1;
        req_select = csr_select;
        req_address = 16'h0044;
        req_data = 32'h55AA55AA;
        @(negedge clk);
        chk_all("rst_mid.c0", 1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        exp_rnw = 1'b1;
        exp_addr = 16'h0044;
        exp_data = 32'h55AA55AA;
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk_all("rst_mid.c1", 1'b1, 1'b1, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_rnw = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_all("rst_mid.after", 1'b0, 1'b0, 1'b0, 32'd0);
            @(posedge clk);
            #1;
        end

        for (int t = 0; t < 60; t++) begin
            run_txn("rand", $urandom_range(3) != 0, 1'(($urandom_range(1))), 16'($urandom), $urandom,
                    $urandom_range(6));
            for (int g = $urandom_range(2); g > 0; g--) begin
                @(negedge clk);
                chk_all("rand.gap", 1'b0, 1'b0, 1'b0, 32'd0);
                @(posedge clk);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
